// File: rtl/vram_pkg.sv
// vram_pkg: shared types and constants for the VRAM copy blocks.
//   copier_state_e   - sync_copier FSM states
//   RdLatencyMin/Max - legal range of the source read latency
package vram_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,  // no reads in flight
        StRead  = 2'd1,  // issuing reads
        StDrain = 2'd2   // waiting out the read pipeline
    } copier_state_e;

    localparam int unsigned RdLatencyMin = 1;
    localparam int unsigned RdLatencyMax = 4;

endpackage

// File: rtl/sync_copier_if.sv
// sync_copier_if: memory-side bus of the copier.
//   addr_from/rden_from/rddata_from - source read port
//   addr_to/byteena_to/wrdata_to/wren_to - destination write port
//   master: the copier; slave: the memories.
interface sync_copier_if #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 11
);

    logic [ADDR_WIDTH-1:0]   addr_from;
    logic                    rden_from;
    logic [DATA_WIDTH-1:0]   rddata_from;
    logic [ADDR_WIDTH-1:0]   addr_to;
    logic [DATA_WIDTH/8-1:0] byteena_to;
    logic [DATA_WIDTH-1:0]   wrdata_to;
    logic                    wren_to;

    modport master (
        output addr_from, rden_from, addr_to, byteena_to, wrdata_to, wren_to,
        input  rddata_from
    );

    modport slave (
        input  addr_from, rden_from, addr_to, byteena_to, wrdata_to, wren_to,
        output rddata_from
    );

endinterface

// File: rtl/addr_delay_line.sv
// addr_delay_line: RD_LATENCY-deep address/valid shift register that lines the
// write address up with source read data.
//   clk, rst_n          - clock, async active-low reset (clears all stages)
//   in_addr, in_valid   - read address / read enable entering the line
//   out_addr, out_valid - delayed address / valid (write side)
//   inflight            - a valid entry sits in a stage before the output
module addr_delay_line #(
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic                  in_valid,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  out_valid,
    output logic                  inflight
);

    logic [ADDR_WIDTH-1:0] addr_q [RD_LATENCY];
    logic [RD_LATENCY-1:0] valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                addr_q[i] <= '0;
            end
        end else begin
            addr_q[0]  <= in_addr;
            valid_q[0] <= in_valid;
            for (int i = 1; i < RD_LATENCY; i++) begin
                addr_q[i]  <= addr_q[i-1];
                valid_q[i] <= valid_q[i-1];
            end
        end
    end

    assign out_addr  = addr_q[RD_LATENCY-1];
    assign out_valid = valid_q[RD_LATENCY-1];

    // The output stage is excluded: once only it is valid, the line is empty
    // after the next edge.
    if (RD_LATENCY > 1) begin : gen_inflight
        assign inflight = |valid_q[RD_LATENCY-2:0];
    end else begin : gen_no_inflight
        assign inflight = 1'b0;
    end

endmodule

// File: rtl/sync_copier.sv
// sync_copier: copies a (wrapping) address region from a source memory to a
// destination memory, one word per cycle.
//   clk, rst_n          - clock, async active-low reset
//   sync                - start pulse (queued one-deep while busy)
//   sync_base, sync_len - first address, word count minus 1
//   abort               - cancel the running copy (in-flight writes finish)
//   clr_done            - clear done while idle
//   busy, done, pending - status: copying, sticky completion, request queued
//   mem                 - source read / destination write bus
module sync_copier
    import vram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned MAX_ADDR   = 2047,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sync,
    input  logic [ADDR_WIDTH-1:0] sync_base,
    input  logic [ADDR_WIDTH-1:0] sync_len,
    input  logic                  abort,
    input  logic                  clr_done,
    output logic                  busy,
    output logic                  done,
    output logic                  pending,
    sync_copier_if.master         mem
);

    // Illegal latencies clamp to the legal range.
    localparam int unsigned Lat = (RD_LATENCY < RdLatencyMin) ? RdLatencyMin :
                                  (RD_LATENCY > RdLatencyMax) ? RdLatencyMax : RD_LATENCY;
    localparam logic [ADDR_WIDTH-1:0] MaxAddr = ADDR_WIDTH'(MAX_ADDR);

    copier_state_e         state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;      // reads still to issue after this one
    logic [ADDR_WIDTH-1:0] qbase_q, qbase_d;
    logic [ADDR_WIDTH-1:0] qlen_q, qlen_d;
    logic                  done_q, done_d;
    logic                  pending_q, pending_d;
    logic                  aborted_q, aborted_d;
    logic                  launch;
    logic                  rden;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic [ADDR_WIDTH-1:0] pipe_addr;
    logic                  pipe_valid;
    logic                  inflight;

    assign next_addr = (addr_q == MaxAddr) ? '0 : addr_q + 1'b1;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q    <= '0;
            cnt_q     <= '0;
            qbase_q   <= '0;
            qlen_q    <= '0;
            done_q    <= 1'b0;
            pending_q <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            qbase_q   <= qbase_d;
            qlen_q    <= qlen_d;
            done_q    <= done_d;
            pending_q <= pending_d;
            aborted_q <= aborted_d;
        end
    end

    // Next state
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        qbase_d   = qbase_q;
        qlen_d    = qlen_q;
        done_d    = done_q;
        pending_d = pending_q;
        aborted_d = aborted_q;
        launch    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (sync) begin
                    state_d   = StRead;
                    addr_d    = sync_base;
                    cnt_d     = sync_len;
                    done_d    = 1'b0;
                    aborted_d = 1'b0;
                end else if (clr_done) begin
                    done_d = 1'b0;
                end
            end
            StRead: begin
                // Also ends the one-cycle done pulse of a back-to-back launch.
                done_d = 1'b0;
                if (abort || cnt_q == '0) begin
                    state_d = StDrain;
                end else begin
                    addr_d = next_addr;
                    cnt_d  = cnt_q - 1'b1;
                end
            end
            StDrain: begin
                if (!inflight) begin
                    done_d = !(aborted_q || abort);
                    // A sync arriving on this very edge is newer than the queue.
                    if (!abort && (sync || pending_q)) begin
                        launch    = 1'b1;
                        state_d   = StRead;
                        addr_d    = sync ? sync_base : qbase_q;
                        cnt_d     = sync ? sync_len : qlen_q;
                        pending_d = 1'b0;
                        aborted_d = 1'b0;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (state_q != StIdle && !launch) begin
            if (abort) begin
                pending_d = 1'b0;
                aborted_d = 1'b1;
            end else if (sync) begin
                pending_d = 1'b1;
                qbase_d   = sync_base;
                qlen_d    = sync_len;
            end
        end
    end

    // Outputs
    always_comb begin
        busy           = (state_q != StIdle);
        rden           = (state_q == StRead);
        mem.rden_from  = rden;
        mem.addr_from  = addr_q;
        mem.addr_to    = pipe_addr;
        mem.wren_to    = pipe_valid;
        mem.byteena_to = {(DATA_WIDTH/8){pipe_valid}};
        mem.wrdata_to  = mem.rddata_from;
    end

    assign done    = done_q;
    assign pending = pending_q;

    addr_delay_line #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .RD_LATENCY (Lat)
    ) u_addr_delay_line (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_addr   (addr_q),
        .in_valid  (rden),
        .out_addr  (pipe_addr),
        .out_valid (pipe_valid),
        .inflight  (inflight)
    );

endmodule

// File: tb/tb_sync_copier.sv
// tb_sync_copier: directed bench for sync_copier at read latencies 1, 2 and 3.
module tb_sync_copier;

    localparam int unsigned DW = 64;
    localparam int unsigned AW = 11;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] src(input logic [AW-1:0] a);
        return {21'h1ABCD, a, ~a, a ^ 11'h5A5, 10'h3C3};
    endfunction

    // DUT a: RD_LATENCY=1, DUT b: 2, DUT c: 3
    logic sync_a, abort_a, clr_a, busy_a, done_a, pending_a;
    logic sync_b, abort_b, clr_b, busy_b, done_b, pending_b;
    logic sync_c, abort_c, clr_c, busy_c, done_c, pending_c;
    logic [AW-1:0] base_a, len_a, base_b, len_b, base_c, len_c;

    sync_copier_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if_a ();
    sync_copier_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if_b ();
    sync_copier_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if_c ();

    sync_copier #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_ADDR(2047), .RD_LATENCY(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .sync(sync_a), .sync_base(base_a), .sync_len(len_a),
        .abort(abort_a), .clr_done(clr_a), .busy(busy_a), .done(done_a), .pending(pending_a),
        .mem(if_a)
    );
    sync_copier #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_ADDR(2047), .RD_LATENCY(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .sync(sync_b), .sync_base(base_b), .sync_len(len_b),
        .abort(abort_b), .clr_done(clr_b), .busy(busy_b), .done(done_b), .pending(pending_b),
        .mem(if_b)
    );
    sync_copier #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_ADDR(2047), .RD_LATENCY(3)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .sync(sync_c), .sync_base(base_c), .sync_len(len_c),
        .abort(abort_c), .clr_done(clr_c), .busy(busy_c), .done(done_c), .pending(pending_c),
        .mem(if_c)
    );

    // Source memories with the matching read latency
    logic [DW-1:0] pa;
    logic [DW-1:0] pb [2];
    logic [DW-1:0] pc [3];
    always @(posedge clk) begin
        pa    <= if_a.rden_from ? src(if_a.addr_from) : '0;
        pb[0] <= if_b.rden_from ? src(if_b.addr_from) : '0;
        pb[1] <= pb[0];
        pc[0] <= if_c.rden_from ? src(if_c.addr_from) : '0;
        pc[1] <= pc[0];
        pc[2] <= pc[1];
    end
    assign if_a.rddata_from = pa;
    assign if_b.rddata_from = pb[1];
    assign if_c.rddata_from = pc[2];

    // Destination write logs
    logic [AW-1:0] wa_addr[$];
    logic [AW-1:0] wb_addr[$];
    logic [AW-1:0] wc_addr[$];
    int            wb_cyc[$];
    int            bad_data = 0;
    int            bad_be   = 0;

    always @(negedge clk) begin
        if (if_a.wren_to) begin
            wa_addr.push_back(if_a.addr_to);
            if (if_a.wrdata_to !== src(if_a.addr_to)) bad_data++;
        end
        if (if_b.wren_to) begin
            wb_addr.push_back(if_b.addr_to);
            wb_cyc.push_back(cyc);
            if (if_b.wrdata_to !== src(if_b.addr_to)) bad_data++;
        end
        if (if_c.wren_to) begin
            wc_addr.push_back(if_c.addr_to);
            if (if_c.wrdata_to !== src(if_c.addr_to)) bad_data++;
        end
        if (if_a.byteena_to !== {8{if_a.wren_to}}) bad_be++;
        if (if_b.byteena_to !== {8{if_b.wren_to}}) bad_be++;
        if (if_c.byteena_to !== {8{if_c.wren_to}}) bad_be++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int k;
        int errs;
        int gap;
        int c0;
        int last_wr;
        logic done_seen;

        {sync_a, abort_a, clr_a, sync_b, abort_b, clr_b, sync_c, abort_c, clr_c} = '0;
        {base_a, len_a, base_b, len_b, base_c, len_c} = '0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        step(2);

        // Reset values
        check("rst_busy",      busy_a, 0);
        check("rst_done",      done_a, 0);
        check("rst_pending",   pending_a, 0);
        check("rst_rden",      if_a.rden_from, 0);
        check("rst_addr_from", if_a.addr_from, 0);
        check("rst_wren",      if_a.wren_to, 0);
        check("rst_addr_to",   if_a.addr_to, 0);
        check("rst_byteena",   if_a.byteena_to, 0);
        rst_n = 1'b1;
        step(1);

        // Full memory, latency 1
        base_a = 11'd0; len_a = 11'd2047; sync_a = 1'b1;
        step(1);
        sync_a = 1'b0;
        k = 0;
        check("full_busy0", busy_a, 1);
        check("full_rden0", if_a.rden_from, 1);
        check("full_addr0", if_a.addr_from, 0);
        while (!done_a && k < 3000) begin step(1); k++; end
        check("full_done_cycles", k, 2049);
        check("full_busy_end", busy_a, 0);
        check("full_nwrites", wa_addr.size(), 2048);
        errs = 0;
        for (int i = 0; i < wa_addr.size(); i++) if (wa_addr[i] !== 11'(i)) errs++;
        check("full_write_addrs", errs, 0);

        // abort in idle does nothing; sync beats clr_done
        abort_a = 1'b1;
        step(1);
        abort_a = 1'b0;
        check("idle_abort_done", done_a, 1);
        check("idle_abort_busy", busy_a, 0);
        wa_addr.delete();
        base_a = 11'd10; len_a = 11'd0; sync_a = 1'b1; clr_a = 1'b1;
        step(1);
        sync_a = 1'b0; clr_a = 1'b0;
        k = 0;
        check("syncclr_done", done_a, 0);
        check("syncclr_busy", busy_a, 1);
        while (!done_a && k < 20) begin step(1); k++; end
        check("single_done_cycles", k, 2);
        check("single_nwrites", wa_addr.size(), 1);
        if (wa_addr.size() == 1) check("single_addr", wa_addr[0], 10);
        clr_a = 1'b1;
        step(1);
        clr_a = 1'b0;
        check("clr_done_idle", done_a, 0);

        // Queued request, later sync overwrites the queue
        wa_addr.delete();
        base_a = 11'd200; len_a = 11'd7; sync_a = 1'b1;
        step(1);
        k = 0;
        base_a = 11'd50; len_a = 11'd1;
        step(1);
        k = 1;
        check("queue_pending", pending_a, 1);
        base_a = 11'd100; len_a = 11'd3;
        step(1);
        k = 2;
        sync_a = 1'b0;
        check("queue_pending2", pending_a, 1);
        gap = 0;
        while (!done_a && k < 40) begin step(1); k++; if (!busy_a) gap++; end
        check("queue_first_done", k, 9);
        check("queue_busy_kept", busy_a, 1);
        check("queue_pending_clr", pending_a, 0);
        check("queue_launch_addr", if_a.addr_from, 100);
        step(1);
        k++;
        check("queue_done_pulse", done_a, 0);
        while (!done_a && k < 60) begin step(1); k++; if (!busy_a && !done_a) gap++; end
        check("queue_second_done", k, 14);
        check("queue_no_idle", gap, 0);
        check("queue_nwrites", wa_addr.size(), 12);
        errs = 0;
        for (int i = 0; i < wa_addr.size(); i++) begin
            if (wa_addr[i] !== ((i < 8) ? 11'(200 + i) : 11'(100 + i - 8))) errs++;
        end
        check("queue_write_addrs", errs, 0);

        // Reset in the middle of a copy
        wa_addr.delete();
        base_a = 11'd0; len_a = 11'd20; sync_a = 1'b1;
        step(1);
        sync_a = 1'b0;
        step(5);
        #1;
        check("midrst_wren_before", if_a.wren_to, 1);
        check("midrst_writes_before", wa_addr.size(), 5);
        rst_n = 1'b0;
        #1;
        check("midrst_wren",    if_a.wren_to, 0);
        check("midrst_busy",    busy_a, 0);
        check("midrst_rden",    if_a.rden_from, 0);
        check("midrst_addr",    {if_a.addr_from, if_a.addr_to}, 0);
        check("midrst_byteena", if_a.byteena_to, 0);
        check("midrst_flags",   {done_a, pending_a}, 0);
        step(2);
        rst_n = 1'b1;
        step(3);
        check("midrst_no_residual", wa_addr.size(), 5);
        check("midrst_idle", busy_a, 0);
        wa_addr.delete();
        base_a = 11'd5; len_a = 11'd2; sync_a = 1'b1;
        step(1);
        sync_a = 1'b0;
        k = 0;
        while (!done_a && k < 20) begin step(1); k++; end
        check("postrst_done_cycles", k, 4);
        check("postrst_nwrites", wa_addr.size(), 3);
        errs = 0;
        for (int i = 0; i < wa_addr.size(); i++) if (wa_addr[i] !== 11'(5 + i)) errs++;
        check("postrst_write_addrs", errs, 0);

        // Region wrapping past the top, latency 3
        base_c = 11'd2040; len_c = 11'd15; sync_c = 1'b1;
        step(1);
        sync_c = 1'b0;
        k = 0;
        while (!done_c && k < 100) begin step(1); k++; end
        check("wrap_done_cycles", k, 19);
        check("wrap_nwrites", wc_addr.size(), 16);
        errs = 0;
        for (int i = 0; i < wc_addr.size(); i++) if (wc_addr[i] !== 11'((2040 + i) % 2048)) errs++;
        check("wrap_write_addrs", errs, 0);

        // Abort during the third read, latency 2, with a queued request
        base_b = 11'd300; len_b = 11'd9; sync_b = 1'b1;
        step(1);
        sync_b = 1'b0;
        c0 = cyc;
        step(1);
        sync_b = 1'b1; base_b = 11'd900; len_b = 11'd0;
        step(1);
        sync_b = 1'b0; abort_b = 1'b1;
        check("abort_pending_set", pending_b, 1);
        check("abort_third_read", {if_b.rden_from, if_b.addr_from}, {1'b1, 11'd302});
        step(1);
        abort_b = 1'b0;
        k = 3;
        check("abort_pending_clr", pending_b, 0);
        check("abort_rden_off", if_b.rden_from, 0);
        done_seen = done_b;
        while (busy_b && k < 40) begin step(1); k++; done_seen = done_seen | done_b; end
        step(3);
        done_seen = done_seen | done_b;
        check("abort_nwrites", wb_addr.size(), 3);
        errs = 0;
        for (int i = 0; i < wb_addr.size(); i++) if (wb_addr[i] !== 11'(300 + i)) errs++;
        check("abort_write_addrs", errs, 0);
        last_wr = (wb_cyc.size() > 0) ? wb_cyc[wb_cyc.size() - 1] - c0 : -1;
        check("abort_last_write_cycle", last_wr, 4);
        check("abort_busy_fall_cycle", k, 5);
        check("abort_no_done", done_seen, 0);
        check("abort_idle_after", busy_b, 0);

        check("write_data", bad_data, 0);
        check("byteena_track", bad_be, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
